// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to single APB3 transfer requester with registered outputs.
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..255");
    end

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0]          cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    pwrite_d    = cmd_write;
                    // Misaligned requests are answered locally without touching the bus
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT_CYCLES)) begin
                        state_d     = RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven and randomized checks of apb_master_bridge against a transaction-level model.
module tb_apb_master_bridge;
    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          waits_cfg = 0;
    logic        err_cfg = 1'b0;
    logic [31:0] rdata_cfg = '0;
    logic [7:0]  acc_cnt;
    int          n_chk = 0;
    int          n_pass = 0;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave: inserts waits_cfg wait states into each ACCESS phase
    always @(posedge pclk or posedge preset)
        if (preset) acc_cnt <= '0;
        else acc_cnt <= (psel && penable && !pready) ? acc_cnt + 8'd1 : 8'd0;
    assign pready  = psel && penable && (int'(acc_cnt) >= waits_cfg);
    assign pslverr = err_cfg;
    assign prdata  = rdata_cfg;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        int          rsp_delay;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_acc;
    } txn_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        bit mis = (t.addr % 4) != 0;
        r.exp_err   = mis || t.err;
        r.exp_rdata = (!t.write && !r.exp_err) ? t.rdata : 32'h0;
        r.exp_acc   = mis ? 0 : t.waits + 1;
        r.exp_lat   = mis ? 1 : t.waits + 3;
        return r;
    endfunction

    task automatic run(input txn_t t);
        int lat = 0, acc = 0;
        bit proto_ok = 1, psel_seen = 0, hold_ok = 1, prev_psel = 0, prev_pen = 0;
        logic [31:0] rd;
        waits_cfg = t.waits; err_cfg = t.err; rdata_cfg = t.rdata;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge pclk);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr; cmd_wdata = t.wdata;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0; cmd_write = ~t.write; cmd_addr = $urandom; cmd_wdata = $urandom;
        while (lat < 200) begin
            @(negedge pclk);
            lat++;
            if (psel) begin
                psel_seen = 1;
                if (paddr !== t.addr || pwdata !== t.wdata || pwrite !== t.write) proto_ok = 0;
            end
            if (psel && penable) acc++;
            if (penable && !psel) proto_ok = 0;
            if (penable && !prev_pen && !prev_psel) proto_ok = 0;
            if (cmd_ready) proto_ok = 0;
            prev_psel = psel; prev_pen = penable;
            if (rsp_valid) break;
        end
        chk("latency", lat, t.exp_lat);
        chk("access_cycles", acc, t.exp_acc);
        chk("psel_seen", {31'b0, psel_seen}, {31'b0, t.exp_acc != 0});
        chk("protocol", {31'b0, proto_ok}, 32'd1);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, t.exp_err});
        chk("rsp_rdata", rsp_rdata, t.exp_rdata);
        chk("paddr_latched", paddr, t.addr);
        rd = rsp_rdata;
        for (int i = 0; i < t.rsp_delay; i++) begin
            @(negedge pclk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_err !== t.exp_err || cmd_ready || psel) hold_ok = 0;
        end
        if (t.rsp_delay > 0) chk("rsp_hold", {31'b0, hold_ok}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        @(negedge pclk);
        chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        chk("cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    endtask

    txn_t tbl[7];
    txn_t t;

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 0, 1'b0, 32'hCAFE_0000, 0, 1'b0, 32'h0, 3, 1};
        tbl[1] = '{1'b0, 32'h0000_0004, 32'h0BAD_F00D, 3, 1'b0, 32'hAAAA_AAAA, 0, 1'b0, 32'hAAAA_AAAA, 6, 4};
        tbl[2] = '{1'b0, 32'h0000_0010, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 0, 1'b1, 32'h0, 3, 1};
        tbl[3] = '{1'b1, 32'h0000_0002, 32'h7777_7777, 0, 1'b0, 32'h0, 0, 1'b1, 32'h0, 1, 0};
        tbl[4] = '{1'b0, 32'h0000_0008, 32'h0, 1, 1'b0, 32'h0000_0055, 5, 1'b0, 32'h0000_0055, 4, 2};
        tbl[5] = '{1'b0, 32'h0000_0101, 32'h0, 0, 1'b0, 32'hFFFF_FFFF, 2, 1'b1, 32'h0, 1, 0};
        tbl[6] = '{1'b1, 32'h0000_000C, 32'h1111_2222, 2, 1'b1, 32'h3333_4444, 1, 1'b1, 32'h0, 5, 3};

        repeat (3) @(negedge pclk);
        chk("reset_apb", {psel, penable, pwrite, 29'b0}, 32'h0);
        chk("reset_paddr", paddr, 32'h0);
        chk("reset_pwdata", pwdata, 32'h0);
        chk("reset_rsp", {rsp_valid, rsp_err, cmd_ready, 29'b0}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        preset = 1'b0;
        @(negedge pclk);
        chk("cmd_ready_post_reset", {31'b0, cmd_ready}, 32'd1);

        foreach (tbl[i]) run(tbl[i]);

        // Reset mid-ACCESS: bus drops asynchronously and no response follows
        waits_cfg = 10; err_cfg = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !penable; i++) @(negedge pclk);
        chk("mid_access_reached", {31'b0, penable}, 32'd1);
        #2 preset = 1'b1;
        #1;
        chk("async_reset_bus", {psel, penable, rsp_valid, cmd_ready, 28'b0}, 32'h0);
        @(negedge pclk);
        preset = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge pclk);
                if (rsp_valid || psel) seen = 1;
            end
            chk("no_rsp_after_reset", {31'b0, seen}, 32'd0);
        end
        run(tbl[1]);

`ifdef APB_MASTER_TIMEOUT_EN
        t = '{1'b0, 32'h0000_0020, 32'h0, 100, 1'b0, 32'h1234_5678, 0, 1'b1, 32'h0, 18, 16};
        run(t);
`endif

        for (int n = 0; n < 30; n++) begin
            t.write     = 1'($urandom);
            t.addr      = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            t.wdata     = $urandom;
            t.waits     = $urandom_range(0, 4);
            t.err       = ($urandom_range(0, 3) == 0);
            t.rdata     = $urandom;
            t.rsp_delay = $urandom_range(0, 2);
            run(model(t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
